// File: rtl/fetch_prediction_gshare.sv
// Gshare branch predictor for the fetch stage: it owns a speculative global history register and
// internal PHT/BTB arrays that a walking init sequence clears after reset.
module fetch_prediction_gshare #(
    parameter int PHT_IDX_W = 11,
    parameter int GHR_W     = 8,
    parameter int BTB_IDX_W = 9,
    parameter int BTB_TAG_W = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 ready,
    input  logic                 req_valid,
    input  logic [31:0]          req_pc,
    output logic                 resp_valid,
    output logic [1:0]           resp_pattern,
    output logic                 resp_taken,
    output logic                 resp_target_valid,
    output logic [31:0]          resp_target,
    output logic [GHR_W-1:0]     resp_ghr,
    input  logic                 pht_upd_en,
    input  logic [31:0]          pht_upd_pc,
    input  logic [GHR_W-1:0]     pht_upd_ghr,
    input  logic [1:0]           pht_upd_oldpattern,
    input  logic                 pht_upd_taken,
    input  logic                 pht_upd_mispredict,
    input  logic                 btb_upd_en,
    input  logic [31:0]          btb_upd_pc,
    input  logic [31:0]          btb_upd_target
);

    localparam int CNT_W   = (PHT_IDX_W > BTB_IDX_W) ? PHT_IDX_W : BTB_IDX_W;
    localparam int PHT_N   = 2 ** PHT_IDX_W;
    localparam int BTB_N   = 2 ** BTB_IDX_W;
    localparam int ENTRY_W = 1 + BTB_TAG_W + 30;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GHR_W-1:0]   ghr_spec;

    logic [1:0]         pht_mem [PHT_N];
    logic [ENTRY_W-1:0] btb_mem [BTB_N];

    logic                 pht_we, btb_we;
    logic [PHT_IDX_W-1:0] pht_wa, req_pht_idx, upd_pht_idx;
    logic [1:0]           pht_wd, pht_step, pht_rd;
    logic [BTB_IDX_W-1:0] btb_wa, btb_ra;
    logic [ENTRY_W-1:0]   btb_wd, btb_rd;
    logic [BTB_TAG_W-1:0] req_tag;
    logic                 btb_hit;
    logic                 lookup_fire;
    logic                 unused_bits;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output of this process gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_INIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == '1) state_d = S_RUN;
            end
            default: ;
        endcase
    end

    assign ready       = (state_q == S_RUN);
    assign lookup_fire = req_valid && ready;

    assign req_pht_idx = req_pc[PHT_IDX_W+1:2]     ^ PHT_IDX_W'(ghr_spec);
    assign upd_pht_idx = pht_upd_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(pht_upd_ghr);
    assign btb_ra      = req_pc[BTB_IDX_W+1:2];
    assign req_tag     = req_pc[BTB_IDX_W+BTB_TAG_W+1:BTB_IDX_W+2];

    // Saturating step; 01/00 predict taken, 10/11 predict not-taken.
    always_comb begin
        pht_step = pht_upd_oldpattern;
        if (pht_upd_taken) begin
            case (pht_upd_oldpattern)
                2'b11:   pht_step = 2'b10;
                2'b10:   pht_step = 2'b00;
                default: pht_step = 2'b01;
            endcase
        end else begin
            case (pht_upd_oldpattern)
                2'b01:   pht_step = 2'b00;
                2'b00:   pht_step = 2'b10;
                default: pht_step = 2'b11;
            endcase
        end
    end

    // Single write port per array, shared by the init walk and training.
    always_comb begin
        pht_we = 1'b0;
        pht_wa = upd_pht_idx;
        pht_wd = pht_step;
        btb_we = 1'b0;
        btb_wa = btb_upd_pc[BTB_IDX_W+1:2];
        btb_wd = {1'b1, btb_upd_pc[BTB_IDX_W+BTB_TAG_W+1:BTB_IDX_W+2], btb_upd_target[31:2]};
        if (state_q == S_INIT) begin
            pht_we = ({{(32-CNT_W){1'b0}}, cnt_q} < 32'(PHT_N));
            pht_wa = cnt_q[PHT_IDX_W-1:0];
            pht_wd = 2'b10;
            btb_we = ({{(32-CNT_W){1'b0}}, cnt_q} < 32'(BTB_N));
            btb_wa = cnt_q[BTB_IDX_W-1:0];
            btb_wd = '0;
        end else begin
            pht_we = pht_upd_en;
            btb_we = btb_upd_en;
        end
    end

    // NOTE: the arrays carry no reset; the init walk clears them, which keeps
    // them mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (pht_we) pht_mem[pht_wa] <= pht_wd;
        if (btb_we) btb_mem[btb_wa] <= btb_wd;
    end

    // Write-first bypass: a same-cycle write to the looked-up index wins.
    assign pht_rd  = (pht_we && pht_wa == req_pht_idx) ? pht_wd : pht_mem[req_pht_idx];
    assign btb_rd  = (btb_we && btb_wa == btb_ra)      ? btb_wd : btb_mem[btb_ra];
    assign btb_hit = btb_rd[ENTRY_W-1] && (btb_rd[ENTRY_W-2:30] == req_tag);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid        <= 1'b0;
            resp_pattern      <= 2'b00;
            resp_taken        <= 1'b0;
            resp_target_valid <= 1'b0;
            resp_target       <= '0;
            resp_ghr          <= '0;
        end else begin
            resp_valid <= lookup_fire;
            if (lookup_fire) begin
                resp_pattern      <= pht_rd;
                resp_taken        <= ~pht_rd[1];
                resp_target_valid <= btb_hit;
                resp_target       <= {btb_rd[29:0], 2'b00};
                resp_ghr          <= ghr_spec;
            end
        end
    end

    // A resolved mispredict rebuilds history from the branch's snapshot and
    // overrides any speculative shift from a prediction leaving this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ghr_spec <= '0;
        end else if (ready && pht_upd_en && pht_upd_mispredict) begin
            ghr_spec <= {pht_upd_ghr[GHR_W-2:0], pht_upd_taken};
        end else if (resp_valid && resp_target_valid) begin
            ghr_spec <= {ghr_spec[GHR_W-2:0], resp_taken};
        end
    end

    assign unused_bits = ^{req_pc, pht_upd_pc, btb_upd_pc, btb_upd_target[1:0]};

endmodule
